// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the framebuffer write arbiter.
// Source encoding matches the out_src port: 0 = gfx producer, 1 = fade write-back.
package fb_arb_pkg;

    typedef enum logic {
        SRC_GFX  = 1'b0,
        SRC_FADE = 1'b1
    } fb_src_t;

    localparam int unsigned DEFAULT_IN0_WEIGHT = 4;
    localparam int unsigned DEFAULT_IN1_WEIGHT = 1;

    // Width of a run counter that must hold values up to the larger weight.
    function automatic int unsigned run_width(input int unsigned w0, input int unsigned w1);
        int unsigned w_max;
        w_max = (w0 > w1) ? w0 : w1;
        return (w_max < 1) ? 1 : $clog2(w_max + 1);
    endfunction

endpackage

// File: rtl/fb_arb_wrr.sv
// Weighted round-robin grant select for two sources.
// The owner/run pair tracks who was granted last and how many consecutive grants it has had.
module fb_arb_wrr
    import fb_arb_pkg::*;
#(
    parameter int unsigned IN0_WEIGHT = DEFAULT_IN0_WEIGHT,
    parameter int unsigned IN1_WEIGHT = DEFAULT_IN1_WEIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic load_en_i,
    output logic grant_valid_o,
    output logic grant_o
);

    localparam int unsigned RUN_W = run_width(IN0_WEIGHT, IN1_WEIGHT);
    localparam logic [RUN_W-1:0] W0_RUN  = RUN_W'(IN0_WEIGHT);
    localparam logic [RUN_W-1:0] W1_RUN  = RUN_W'(IN1_WEIGHT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    if (IN0_WEIGHT < 1) begin : g_bad_in0_weight
        $error("fb_arb_wrr: IN0_WEIGHT must be >= 1");
    end
    if (IN1_WEIGHT < 1) begin : g_bad_in1_weight
        $error("fb_arb_wrr: IN1_WEIGHT must be >= 1");
    end

    fb_src_t          owner_q, owner_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] owner_weight;
    fb_src_t          other;
    fb_src_t          grant;
    logic             grant_valid;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        owner_weight = (owner_q == SRC_GFX) ? W0_RUN : W1_RUN;
        other        = (owner_q == SRC_GFX) ? SRC_FADE : SRC_GFX;
        grant_valid  = load_en_i && (valid0_i || valid1_i);
        grant        = SRC_GFX;

        // Contention is the only case where the run length matters.
        if (valid0_i && valid1_i) begin
            grant = (run_q < owner_weight) ? owner_q : other;
        end else if (valid1_i) begin
            grant = SRC_FADE;
        end

        owner_d = owner_q;
        run_d   = run_q;
        if (grant_valid) begin
            if (grant == owner_q) begin
                run_d = (run_q < owner_weight) ? run_q + RUN_ONE : run_q;
            end else begin
                owner_d = grant;
                run_d   = RUN_ONE;
            end
        end
    end

    // Reset marks in1's run as exhausted so in0 wins the first contention.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= SRC_FADE;
            run_q   <= W1_RUN;
        end else begin
            owner_q <= owner_d;
            run_q   <= run_d;
        end
    end

    assign grant_valid_o = grant_valid;
    assign grant_o       = grant;

endmodule

// File: rtl/fb_write_arbiter.sv
// Two-to-one framebuffer write arbiter: weighted round-robin between gfx and fade
// write-back, feeding a single registered full-throughput output stage.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned PIXEL_BITS     = 16,
    parameter int unsigned IN0_WEIGHT     = DEFAULT_IN0_WEIGHT,
    parameter int unsigned IN1_WEIGHT     = DEFAULT_IN1_WEIGHT
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in0_axi_tvalid,
    output logic                      in0_axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] in0_addr,
    input  logic [PIXEL_BITS-1:0]     in0_color,

    input  logic                      in1_axi_tvalid,
    output logic                      in1_axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] in1_addr,
    input  logic [PIXEL_BITS-1:0]     in1_color,

    output logic                      out_axi_tvalid,
    input  logic                      out_axi_tready,
    output logic [AXI_ADDR_WIDTH-1:0] out_addr,
    output logic [PIXEL_BITS-1:0]     out_color,
    output logic                      out_src
);

    logic                      load_en;
    logic                      grant_valid;
    logic                      grant;

    logic                      out_valid_q, out_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [PIXEL_BITS-1:0]     out_color_q, out_color_d;
    logic                      out_src_q,   out_src_d;

    // The output stage can take a new beat whenever it is empty or being drained.
    assign load_en = !out_valid_q || out_axi_tready;

    fb_arb_wrr #(
        .IN0_WEIGHT (IN0_WEIGHT),
        .IN1_WEIGHT (IN1_WEIGHT)
    ) u_wrr (
        .clk           (clk),
        .reset         (reset),
        .valid0_i      (in0_axi_tvalid),
        .valid1_i      (in1_axi_tvalid),
        .load_en_i     (load_en),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    assign in0_axi_tready = grant_valid && (grant == SRC_GFX);
    assign in1_axi_tready = grant_valid && (grant == SRC_FADE);

    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_color_d = out_color_q;
        out_src_d   = out_src_q;

        // Without a grant only valid drops; the payload holds its last value.
        if (load_en) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_src_d   = grant;
                out_addr_d  = (grant == SRC_FADE) ? in1_addr  : in0_addr;
                out_color_d = (grant == SRC_FADE) ? in1_color : in0_color;
            end
        end
    end

    // NOTE: payload registers are reset too, because the output bus must read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_color_q <= '0;
            out_src_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_color_q <= out_color_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_axi_tvalid = out_valid_q;
    assign out_addr       = out_addr_q;
    assign out_color      = out_color_q;
    assign out_src        = out_src_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with IN0_WEIGHT=4, IN1_WEIGHT=1.
module tb_fb_write_arbiter;

    logic        clk;
    logic        reset;
    logic        in0_axi_tvalid, in0_axi_tready;
    logic [19:0] in0_addr;
    logic [15:0] in0_color;
    logic        in1_axi_tvalid, in1_axi_tready;
    logic [19:0] in1_addr;
    logic [15:0] in1_color;
    logic        out_axi_tvalid, out_axi_tready;
    logic [19:0] out_addr;
    logic [15:0] out_color;
    logic        out_src;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned exp_src_both  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int unsigned exp_src_late  [5]  = '{1, 0, 0, 0, 0};
    int unsigned exp_src_stall [4]  = '{0, 0, 0, 1};

    fb_write_arbiter #(
        .AXI_ADDR_WIDTH (20),
        .PIXEL_BITS     (16),
        .IN0_WEIGHT     (4),
        .IN1_WEIGHT     (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in0_axi_tvalid (in0_axi_tvalid),
        .in0_axi_tready (in0_axi_tready),
        .in0_addr       (in0_addr),
        .in0_color      (in0_color),
        .in1_axi_tvalid (in1_axi_tvalid),
        .in1_axi_tready (in1_axi_tready),
        .in1_addr       (in1_addr),
        .in1_color      (in1_color),
        .out_axi_tvalid (out_axi_tvalid),
        .out_axi_tready (out_axi_tready),
        .out_addr       (out_addr),
        .out_color      (out_color),
        .out_src        (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        in0_axi_tvalid = 1'b0;
        in0_addr       = '0;
        in0_color      = '0;
        in1_axi_tvalid = 1'b0;
        in1_addr       = '0;
        in1_color      = '0;
        out_axi_tready = 1'b1;
        tick();
        tick();

        check("rst_valid", 32'(out_axi_tvalid), 32'd0);
        check("rst_addr",  32'(out_addr),       32'd0);
        check("rst_color", 32'(out_color),      32'd0);
        check("rst_src",   32'(out_src),        32'd0);
        reset = 1'b0;

        // Test 1: load an in1 beat, then assert reset between edges.
        in1_axi_tvalid = 1'b1;
        in1_addr       = 20'hABC;
        in1_color      = 16'hBEEF;
        #1;
        check("t1_in1_ready", 32'(in1_axi_tready), 32'd1);
        tick();
        in1_axi_tvalid = 1'b0;
        check("t1_pre_valid", 32'(out_axi_tvalid), 32'd1);
        check("t1_pre_addr",  32'(out_addr),       32'hABC);
        check("t1_pre_src",   32'(out_src),        32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t1_async_valid", 32'(out_axi_tvalid), 32'd0);
        check("t1_async_addr",  32'(out_addr),       32'd0);
        check("t1_async_src",   32'(out_src),        32'd0);
        check("t1_async_color", 32'(out_color),      32'd0);
        tick();
        reset = 1'b0;

        // Test 2: in0 streams addresses 0..7 alone.
        for (int i = 0; i < 8; i++) begin
            in0_axi_tvalid = 1'b1;
            in0_addr       = 20'(i);
            in0_color      = 16'(16'h100 + i);
            #1;
            check($sformatf("t2_ready_%0d", i), 32'(in0_axi_tready), 32'd1);
            tick();
            check($sformatf("t2_valid_%0d", i), 32'(out_axi_tvalid), 32'd1);
            check($sformatf("t2_addr_%0d", i),  32'(out_addr),       32'(i));
            check($sformatf("t2_src_%0d", i),   32'(out_src),        32'd0);
        end
        check("t2_color_last", 32'(out_color), 32'h107);
        in0_axi_tvalid = 1'b0;
        tick();
        check("t2_idle_valid", 32'(out_axi_tvalid), 32'd0);
        check("t2_idle_hold",  32'(out_addr),       32'd7);

        // Test 3: both sources continuously valid.
        do_reset();
        in0_axi_tvalid = 1'b1;
        in0_addr       = 20'h10;
        in1_axi_tvalid = 1'b1;
        in1_addr       = 20'h20;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t3_valid_%0d", i), 32'(out_axi_tvalid), 32'd1);
            check($sformatf("t3_src_%0d", i),   32'(out_src),        32'(exp_src_both[i]));
            check($sformatf("t3_addr_%0d", i),  32'(out_addr),
                  (exp_src_both[i] == 1) ? 32'h20 : 32'h10);
        end
        in0_axi_tvalid = 1'b0;
        in1_axi_tvalid = 1'b0;
        tick();

        // Test 4: in0 alone saturates its run, then in1 joins.
        in0_axi_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_solo_src_%0d", i), 32'(out_src), 32'd0);
        end
        in1_axi_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_mix_src_%0d", i), 32'(out_src), 32'(exp_src_late[i]));
        end
        in0_axi_tvalid = 1'b0;
        in1_axi_tvalid = 1'b0;
        tick();

        // Test 5: stall with beat 0x123 held while both inputs wait.
        do_reset();
        out_axi_tready = 1'b0;
        in0_axi_tvalid = 1'b1;
        in0_addr       = 20'h123;
        tick();
        in0_addr       = 20'h456;
        in1_axi_tvalid = 1'b1;
        in1_addr       = 20'h789;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_stall_r0_%0d", i),   32'(in0_axi_tready), 32'd0);
            check($sformatf("t5_stall_r1_%0d", i),   32'(in1_axi_tready), 32'd0);
            check($sformatf("t5_stall_addr_%0d", i), 32'(out_addr),       32'h123);
            check($sformatf("t5_stall_vld_%0d", i),  32'(out_axi_tvalid), 32'd1);
            tick();
        end
        out_axi_tready = 1'b1;
        #1;
        check("t5_release_r0", 32'(in0_axi_tready), 32'd1);
        check("t5_release_r1", 32'(in1_axi_tready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_resume_src_%0d", i), 32'(out_src), 32'(exp_src_stall[i]));
            check($sformatf("t5_resume_addr_%0d", i), 32'(out_addr),
                  (exp_src_stall[i] == 1) ? 32'h789 : 32'h456);
        end

        // Test 6: reset while in1 owns the output mid-run.
        in0_axi_tvalid = 1'b0;
        tick();
        check("t6_pre_valid", 32'(out_axi_tvalid), 32'd1);
        check("t6_pre_src",   32'(out_src),        32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_drop_valid", 32'(out_axi_tvalid), 32'd0);
        check("t6_drop_addr",  32'(out_addr),       32'd0);
        tick();
        reset          = 1'b0;
        in0_axi_tvalid = 1'b1;
        #1;
        check("t6_first_r0", 32'(in0_axi_tready), 32'd1);
        check("t6_first_r1", 32'(in1_axi_tready), 32'd0);
        tick();
        check("t6_first_src",  32'(out_src),  32'd0);
        check("t6_first_addr", 32'(out_addr), 32'h456);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Weighted round-robin 2-to-1 arbiter for framebuffer pixel writes.
- Shares one AXI-Stream-style write port between the gfx producer (in0) and the fade write-back producer (in1).
- Sits between the producers and the framebuffer AXI write sequencer.
- Bounded run lengths keep gfx bursts from starving fade write-back, and fade write-back from stalling gfx.

Parameters:
- AXI_ADDR_WIDTH, 20, pixel address width.
- PIXEL_BITS, 16, color+age word width.
- IN0_WEIGHT, 4, max consecutive in0 grants while in1 is waiting (must be >= 1).
- IN1_WEIGHT, 1, max consecutive in1 grants while in0 is waiting (must be >= 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in0_axi_tvalid  in  1  gfx request valid
- in0_axi_tready  out  1  gfx beat accepted this cycle
- in0_addr  in  AXI_ADDR_WIDTH  gfx pixel address
- in0_color  in  PIXEL_BITS  gfx pixel data
- in1_axi_tvalid  in  1  fade request valid
- in1_axi_tready  out  1  fade beat accepted this cycle
- in1_addr  in  AXI_ADDR_WIDTH  fade pixel address
- in1_color  in  PIXEL_BITS  fade pixel data
- out_axi_tvalid  out  1  registered output valid
- out_axi_tready  in  1  downstream ready
- out_addr  out  AXI_ADDR_WIDTH  registered address
- out_color  out  PIXEL_BITS  registered data
- out_src  out  1  source of current output beat (0=in0, 1=in1)

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: out_axi_tvalid=0, out_addr=0, out_color=0, out_src=0, owner=1, run=IN1_WEIGHT. This marks in1's run as exhausted, so in0 wins the first contention.
- load_en = !out_axi_tvalid || out_axi_tready. The output register is a pipeline stage with full throughput: one beat per cycle when out_axi_tready stays high.
- Grant (combinational, only when load_en):
  - Only in0 valid: grant 0.
  - Only in1 valid: grant 1.
  - Neither valid: no grant.
  - Both valid: grant owner if run < weight(owner), else grant the other source.
- inN_axi_tready = load_en && (grant==N). Ready may depend on valid. Producers must not depend on ready to assert valid.
- On grant:
  - out regs load the granted addr/color, out_src=grant, out_axi_tvalid=1.
  - If grant==owner: run=min(run+1, weight(owner)).
  - Else: owner=grant, run=1.
- load_en with no grant: out_axi_tvalid=0; out_addr, out_color and out_src hold their values.
- Stall (out_axi_tvalid && !out_axi_tready):
  - Both readies are 0.
  - out_* hold stable.
  - owner and run are unchanged.
- Latency: an accepted input beat appears on out_* the following cycle.
- Run saturation: while a single source streams alone, run saturates at its weight. When the other source appears, it wins the next contended grant.
- Weights >= 1 are enforced by an elaboration-time assertion.
- Reset mid-operation: the held output beat is discarded (out_axi_tvalid drops immediately) and arbitration state returns to its reset values. Producers must re-present any unaccepted beat.
- No reordering within a source. Each accepted input beat is emitted exactly once.

Decomposition:
- fb_arb_pkg holds:
  - typedef fb_src_t (SRC_GFX=0, SRC_FADE=1).
  - A default-weight localparam pair.
- One sub-module, fb_arb_wrr: owner/run registers and the grant select.
  - Inputs: valid0, valid1, load_en.
  - Outputs: grant_valid, grant.
- Top level: output register plus ready generation.

Test Plan (IN0_WEIGHT=4, IN1_WEIGHT=1):
1. Assert reset asynchronously mid-cycle -> out_axi_tvalid=0, out_addr=0, out_src=0 immediately, without waiting for a clk edge.
2. in0 streams addr 0..7, in1 idle, out_axi_tready=1 -> out_addr 0..7 on consecutive cycles, each 1 cycle after acceptance, out_src=0.
3. Both continuously valid, out_axi_tready=1 -> out_src sequence 0,0,0,0,1,0,0,0,0,1 with no bubbles.
4. in0 alone for 10 beats, then in1 valid with in0 still valid -> next granted beat is out_src=1, then four in0 beats.
5. Beat 0x123 with out_axi_tvalid=1 and out_axi_tready=0 for 3 cycles, both inputs valid -> out_addr stays 0x123, both readies 0. On release, arbitration resumes from the pre-stall owner/run.
6. Assert reset while out_axi_tvalid=1 and in1 is mid-run -> out beat dropped. After release, with both inputs valid, the first grant is in0.
